// File: rtl/serial_sub_pkg.sv
// Shared types and reference model for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    localparam int DATAWIDTH_DEF = 8;
    localparam int REF_W         = 64;

    // Returns {borrow, diff}; operands are zero-extended so bit REF_W is the
    // sign of a - b - bin, i.e. the borrow for any width up to REF_W.
    function automatic logic [REF_W:0] sub_ref(input logic [REF_W-1:0] a,
                                               input logic [REF_W-1:0] b,
                                               input logic             bin);
        logic [REF_W:0] t;
        t = {1'b0, a} - {1'b0, b} - {{REF_W{1'b0}}, bin};
        return t;
    endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set on underflow.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: result = a - b - borrowin, LSB first, one bit per
// clock, with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    input  logic                 borrowin_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [DATAWIDTH-1:0] result_o,
    output logic                 borrowout_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int            CW   = $clog2(DATAWIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

    state_t               state;
    logic [DATAWIDTH-1:0] a_sh, b_sh, res_sh, res_next;
    logic [DATAWIDTH-1:0] a_q, b_q;
    logic                 bin_q, br;
    logic [CW-1:0]        cnt;
    logic                 d, bout;
    logic [REF_W:0]       exp_v;

    serial_sub_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d),
        .bout (bout)
    );

    // New difference bit enters at the MSB; after DATAWIDTH shifts bit 0 is at the LSB.
    generate
        if (DATAWIDTH == 1) begin : g_res_w1
            assign res_next = d;
        end else begin : g_res_wn
            assign res_next = {d, res_sh[DATAWIDTH-1:1]};
        end
    endgenerate

    assign exp_v = sub_ref(REF_W'(a_q), REF_W'(b_q), bin_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            ready_o     <= 1'b1;
            valid_o     <= 1'b0;
            result_o    <= '0;
            borrowout_o <= 1'b0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bin_q       <= 1'b0;
            br          <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_sh    <= a_i;
                        b_sh    <= b_i;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        bin_q   <= borrowin_i;
                        br      <= borrowin_i;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                        state   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= bout;
                    res_sh <= res_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result_o    <= res_next;
                        borrowout_o <= bout;
                        valid_o     <= 1'b1;
                        state       <= DONE;
                        assert ({bout, res_next} == {exp_v[REF_W], exp_v[DATAWIDTH-1:0]});
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sampled-random checks of serial_subtractor at DATAWIDTH=8.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] a_i = '0, b_i = '0;
    logic       borrowin_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic       ready_o, borrowout_o, valid_o;
    logic [7:0] result_o;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.DATAWIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .a_i         (a_i),
        .b_i         (b_i),
        .borrowin_i  (borrowin_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .borrowout_o (borrowout_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_sub(input logic [7:0] a, input logic [7:0] b, input logic bin);
        return {1'b0, a} - {1'b0, b} - {8'd0, bin};
    endfunction

    // Called #1 after a rising edge with the DUT idle.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                          input int hold, input logic junk,
                          output logic [7:0] r, output logic bo);
        int         lat;
        logic [7:0] r0;
        logic       b0;
        check("ready_idle", ready_o, 1);
        a_i = a; b_i = b; borrowin_i = bin; valid_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1;
        if (junk) begin
            a_i = 8'h01; b_i = 8'h01; borrowin_i = 1'b0;
        end else begin
            valid_i = 1'b0;
        end
        check("ready_busy", ready_o, 0);
        lat = 0;
        while (valid_o !== 1'b1 && lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", lat, 8);
        r0 = result_o;
        b0 = borrowout_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            check("hold_valid", valid_o, 1);
            check("hold_ready", ready_o, 0);
            check("hold_result", result_o, r0);
            check("hold_borrow", borrowout_o, b0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        check("post_valid", valid_o, 0);
        check("post_ready", ready_o, 1);
        r  = r0;
        bo = b0;
    endtask

    initial begin
        logic [7:0] r, ra, rb;
        logic       bo, bin;
        logic [8:0] e, s;
        logic       seen;

        // Reset
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_borrow", borrowout_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        check("sub_ref_5_10_1", sub_ref(64'd5, 64'd10, 1'b1) & 64'hFF, 250);

        // Basic
        run_op(8'd100, 8'd58, 1'b0, 0, 1'b0, r, bo);
        check("basic_result", r, 42);
        check("basic_borrow", bo, 0);

        // Underflow
        run_op(8'd5, 8'd10, 1'b1, 0, 1'b0, r, bo);
        check("uf_result", r, 250);
        check("uf_borrow", bo, 1);
        run_op(8'd0, 8'd0, 1'b1, 0, 1'b0, r, bo);
        check("zero_result", r, 255);
        check("zero_borrow", bo, 1);

        // Corners
        run_op(8'd255, 8'd255, 1'b1, 0, 1'b0, r, bo);
        check("ff_ff_1_result", r, 255);
        check("ff_ff_1_borrow", bo, 1);
        run_op(8'd0, 8'd255, 1'b0, 0, 1'b0, r, bo);
        check("0_ff_result", r, 1);
        check("0_ff_borrow", bo, 1);
        run_op(8'd255, 8'd0, 1'b1, 0, 1'b0, r, bo);
        check("ff_0_1_result", r, 254);
        check("ff_0_1_borrow", bo, 0);

        // Backpressure with junk operands offered during COMPUTE/DONE
        run_op(8'd100, 8'd58, 1'b0, 20, 1'b1, r, bo);
        check("bp_result", r, 42);
        check("bp_borrow", bo, 0);
        @(posedge clk_i); #1;
        check("bp_no_capture_valid", valid_o, 0);
        check("bp_no_capture_ready", ready_o, 1);
        check("bp_result_kept", result_o, 42);

        // Reset mid-operation
        a_i = 8'd77; b_i = 8'd3; borrowin_i = 1'b0; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_result", result_o, 0);
        check("mid_rst_borrow", borrowout_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i); #1;
            if (valid_o !== 1'b0) seen = 1'b1;
        end
        check("mid_rst_no_valid", seen, 0);
        run_op(8'd255, 8'd1, 1'b0, 0, 1'b0, r, bo);
        check("after_rst_result", r, 254);
        check("after_rst_borrow", bo, 0);

        // Sampled operand space
        for (int i = 0; i < 300; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            bin = 1'($urandom_range(0, 1));
            e   = exp_sub(ra, rb, bin);
            run_op(ra, rb, bin, 0, 1'b0, r, bo);
            check("rand_result", r, e[7:0]);
            check("rand_borrow", bo, e[8]);
        end

        // Adder inverse: (a + b) - b == a when the sum does not carry
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom_range(0, 127));
            rb = 8'($urandom_range(0, 127));
            s  = {1'b0, ra} + {1'b0, rb};
            run_op(s[7:0], rb, 1'b0, 0, 1'b0, r, bo);
            check("inv_result", r, ra);
            check("inv_borrow", bo, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
